// File: rtl/mult_div_sequencer.sv
// Iterative signed multiply/divide engine producing Hi/Lo register values.
// Ports: clock, reset (async, active-low); start/op/a_in/b_in request;
// busy/done/div_zero/hi_lo_write status; hi_out/lo_out registered results.
module mult_div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             hi_lo_write,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    IDLE, MULT, DIV, FIX, DONE
  } state_t;

  state_t state, state_nxt;

  logic             op_q, sa_q, sb_q, dz_q;
  logic [WIDTH-1:0] ma_q, mb_q;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;

  logic             last;
  logic             b_zero;
  logic [WIDTH-1:0] a_mag, b_mag;

  logic [WIDTH:0]     msum;
  logic [2*WIDTH-1:0] acc_mul;
  logic [WIDTH:0]     dsh, dtr;
  logic [2*WIDTH-1:0] acc_div;

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   q_fix, r_fix;

  assign last   = (cnt == CW'(WIDTH - 1));
  assign b_zero = (b_in == '0);
  assign a_mag  = a_in[WIDTH-1] ? -a_in : a_in;
  assign b_mag  = b_in[WIDTH-1] ? -b_in : b_in;

  // Shift-add: acc = {partial, multiplier}; add into the
  // upper half when the multiplier lsb is set, then shift right.
  assign msum    = {1'b0, acc[2*WIDTH-1:WIDTH]}
                 + {1'b0, (acc[0] ? ma_q : {WIDTH{1'b0}})};
  assign acc_mul = {msum, acc[WIDTH-1:1]};

  // Restoring step: acc = {remainder, dividend/quotient}.
  // A borrow out of the trial subtract restores the old value.
  assign dsh     = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign dtr     = dsh - {1'b0, mb_q};
  assign acc_div = {(dtr[WIDTH] ? dsh[WIDTH-1:0] : dtr[WIDTH-1:0]),
                    acc[WIDTH-2:0], ~dtr[WIDTH]};

  assign prod_fix = (sa_q ^ sb_q) ? -acc : acc;
  assign q_fix    = (sa_q ^ sb_q) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign r_fix    = sa_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  assign busy        = (state != IDLE);
  assign done        = (state == DONE);
  assign div_zero    = done & dz_q;
  assign hi_lo_write = done & ~dz_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (!op)        state_nxt = MULT;
          else if (b_zero) state_nxt = DONE;
          else            state_nxt = DIV;
        end
      end
      MULT:    if (last) state_nxt = FIX;
      DIV:     if (last) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_q   <= 1'b0;
      sa_q   <= 1'b0;
      sb_q   <= 1'b0;
      dz_q   <= 1'b0;
      ma_q   <= '0;
      mb_q   <= '0;
      acc    <= '0;
      cnt    <= '0;
      hi_out <= '0;
      lo_out <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            op_q <= op;
            sa_q <= a_in[WIDTH-1];
            sb_q <= b_in[WIDTH-1];
            dz_q <= op & b_zero;
            ma_q <= a_mag;
            mb_q <= b_mag;
            cnt  <= '0;
            acc  <= {{WIDTH{1'b0}}, (op ? a_mag : b_mag)};
          end
        end
        MULT: begin
          acc <= acc_mul;
          cnt <= cnt + CW'(1);
        end
        DIV: begin
          acc <= acc_div;
          cnt <= cnt + CW'(1);
        end
        FIX: begin
          if (op_q) begin
            hi_out <= r_fix;
            lo_out <= q_fix;
          end else begin
            hi_out <= prod_fix[2*WIDTH-1:WIDTH];
            lo_out <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Scoreboard bench for mult_div_sequencer.
// Expected Hi/Lo come from a 64-bit signed reference model.
module tb_mult_div_sequencer;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic         op;
  logic [W-1:0] a_in, b_in;
  logic         busy, done, div_zero, hi_lo_write;
  logic [W-1:0] hi_out, lo_out;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           due;
  } exp_t;

  exp_t sbq[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int n_done = 0;
  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;

  mult_div_sequencer #(.WIDTH(W)) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .op(op),
    .a_in(a_in),
    .b_in(b_in),
    .busy(busy),
    .done(done),
    .div_zero(div_zero),
    .hi_lo_write(hi_lo_write),
    .hi_out(hi_out),
    .lo_out(lo_out)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic model(input logic o,
                       input logic [W-1:0] a, b,
                       output exp_t e);
    longint la, lb, p, q, r;
    la = longint'($signed(a));
    lb = longint'($signed(b));
    e.dz = 1'b0;
    if (!o) begin
      p = la * lb;
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (b == '0) begin
      e.dz = 1'b1;
      e.hi = exp_hi;
      e.lo = exp_lo;
    end else begin
      q = la / lb;
      r = la % lb;
      e.hi = r[31:0];
      e.lo = q[31:0];
    end
  endtask

  always @(negedge clock) begin
    if (reset && done) begin
      n_done++;
      if (sbq.size() == 0) begin
        chk("sb_empty", 1, 0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("hi", hi_out, e.hi);
        chk("lo", lo_out, e.lo);
        chk("div_zero", div_zero, e.dz);
        chk("hi_lo_write", hi_lo_write, !e.dz);
        chk("done_cycle", cyc, e.due);
      end
    end
  end

  task automatic wait_idle(output int nb);
    nb = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (!busy) break;
      nb++;
    end
  endtask

  task automatic run(input logic o,
                     input logic [W-1:0] a, b);
    exp_t e;
    int nb;
    model(o, a, b, e);
    e.due = cyc + (e.dz ? 1 : W + 2);
    sbq.push_back(e);
    exp_hi = e.hi;
    exp_lo = e.lo;
    start = 1'b1;
    op = o;
    a_in = a;
    b_in = b;
    @(posedge clock);
    #1;
    start = 1'b0;
    op = ~o;
    a_in = $urandom;
    b_in = $urandom;
    wait_idle(nb);
    chk("busy_len", nb, e.dz ? 1 : W + 2);
    chk("hi_hold", hi_out, exp_hi);
    chk("lo_hold", lo_out, exp_lo);
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1);
  end

  initial begin
    int t0, nd, nb;
    exp_t e;
    reset = 1'b0;
    start = 1'b0;
    op = 1'b0;
    a_in = '0;
    b_in = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dz", div_zero, 0);
    chk("rst_hlw", hi_lo_write, 0);
    chk("rst_hi", hi_out, 0);
    chk("rst_lo", lo_out, 0);
    reset = 1'b1;
    @(posedge clock);
    #1;

    run(1'b0, 32'd7, 32'hFFFFFFFD);
    run(1'b1, 32'd100, -32'sd7);
    run(1'b1, -32'sd7, 32'd2);
    run(1'b0, 32'd3, 32'd5);
    run(1'b1, 32'd9, 32'd0);
    run(1'b1, 32'h80000000, 32'hFFFFFFFF);
    run(1'b0, 32'h80000000, 32'h80000000);

    // Restarts while busy are ignored.
    nd = n_done;
    t0 = cyc;
    model(1'b0, 32'd1234, -32'sd56, e);
    e.due = t0 + W + 2;
    sbq.push_back(e);
    exp_hi = e.hi;
    exp_lo = e.lo;
    start = 1'b1;
    op = 1'b0;
    a_in = 32'd1234;
    b_in = -32'sd56;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    start = 1'b1;
    op = 1'b1;
    a_in = 32'd9;
    b_in = 32'd0;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (14) @(posedge clock);
    #1;
    start = 1'b1;
    op = 1'b0;
    a_in = 32'd77;
    b_in = 32'd11;
    @(posedge clock);
    #1;
    start = 1'b0;
    wait_idle(nb);
    chk("restart_done_cnt", n_done - nd, 1);
    chk("restart_hi", hi_out, exp_hi);
    chk("restart_lo", lo_out, exp_lo);
    @(posedge clock);
    #1;

    // Reset mid-divide aborts without done.
    nd = n_done;
    start = 1'b1;
    op = 1'b1;
    a_in = 32'd1000;
    b_in = 32'd7;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clock);
    #2;
    reset = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_hi", hi_out, 0);
    chk("abort_lo", lo_out, 0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    repeat (40) @(posedge clock);
    #1;
    chk("abort_no_done", n_done - nd, 0);
    run(1'b0, 32'd2, 32'd3);

    for (int i = 0; i < 8; i++) begin
      logic [W-1:0] ra, rb;
      ra = $urandom;
      rb = (i == 3) ? '0 : $urandom;
      if (i == 5) rb = 32'd1;
      run(1'(i % 2), ra, rb);
    end

    chk("sb_drained", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
